// File: rtl/cpu_multicycle.sv
// cpu_multicycle: multi-cycle little-computer core. One FSM steps each instruction through
// fetch, decode, execute, memory and writeback, with req/ready handshakes on both memory ports.
module cpu_multicycle #(
   parameter int REG_WIDTH   = 16,
   parameter int NUM_REGS    = 8,
   parameter int INSTR_WIDTH = 16,
   parameter int ADDR_WIDTH  = 16
) (
   input  logic                               CLK,
   input  logic                               RST,
   output logic                               imem_req,
   output logic [ADDR_WIDTH-1:0]              imem_addr,
   input  logic                               imem_ready,
   input  logic [INSTR_WIDTH-1:0]             imem_rdata,
   output logic                               dmem_req,
   output logic                               dmem_we,
   output logic [ADDR_WIDTH-1:0]              dmem_addr,
   output logic [REG_WIDTH-1:0]               dmem_wdata,
   input  logic                               dmem_ready,
   input  logic [REG_WIDTH-1:0]               dmem_rdata,
   output logic [NUM_REGS-1:0][REG_WIDTH-1:0] debug_reg_state,
   output logic                               halted
);
   localparam int RW   = $clog2(NUM_REGS);
   localparam int IMMW = INSTR_WIDTH - 4 - 2*RW;

   localparam logic [3:0] OP_HALT = 4'd0;
   localparam logic [3:0] OP_ADD  = 4'd1;
   localparam logic [3:0] OP_SUB  = 4'd2;
   localparam logic [3:0] OP_AND  = 4'd3;
   localparam logic [3:0] OP_OR   = 4'd4;
   localparam logic [3:0] OP_XOR  = 4'd5;
   localparam logic [3:0] OP_SLT  = 4'd6;
   localparam logic [3:0] OP_ADDI = 4'd7;
   localparam logic [3:0] OP_LW   = 4'd8;
   localparam logic [3:0] OP_SW   = 4'd9;
   localparam logic [3:0] OP_BEQ  = 4'd10;
   localparam logic [3:0] OP_JMP  = 4'd11;

   typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT} state_t;

   state_t                             r_state;
   logic [ADDR_WIDTH-1:0]              r_pc;
   logic [INSTR_WIDTH-1:0]             r_instr;
   logic [REG_WIDTH-1:0]               r_rsVal;
   logic [REG_WIDTH-1:0]               r_rtVal;
   logic [REG_WIDTH-1:0]               r_result;
   logic [NUM_REGS-1:0][REG_WIDTH-1:0] r_regs;
   logic                               r_halted;
   logic                               r_dmemReq;
   logic                               r_dmemWe;
   logic [ADDR_WIDTH-1:0]              r_dmemAddr;
   logic [REG_WIDTH-1:0]               r_dmemWdata;

   logic [3:0]                         w_op;
   logic [RW-1:0]                      w_rs;
   logic [RW-1:0]                      w_rt;
   logic [RW-1:0]                      w_rd;
   logic [RW-1:0]                      w_dest;
   logic signed [IMMW-1:0]             w_immRaw;
   logic [REG_WIDTH-1:0]               w_imm;
   logic [ADDR_WIDTH-1:0]              w_immPc;
   logic [ADDR_WIDTH-1:0]              w_pcInc;
   logic [REG_WIDTH-1:0]               w_aluOut;

   assign w_op     = r_instr[INSTR_WIDTH-1 -: 4];
   assign w_rs     = r_instr[INSTR_WIDTH-5 -: RW];
   assign w_rt     = r_instr[INSTR_WIDTH-5-RW -: RW];
   assign w_rd     = r_instr[IMMW-1 -: RW];
   assign w_immRaw = r_instr[IMMW-1:0];
   assign w_imm    = REG_WIDTH'(w_immRaw);
   assign w_immPc  = ADDR_WIDTH'(w_immRaw);
   assign w_pcInc  = r_pc + ADDR_WIDTH'(1);
   assign w_dest   = (w_op == OP_ADDI || w_op == OP_LW) ? w_rt : w_rd;

   // Fetch request is held off while reset is applied so an abandoned fetch never leaks out.
   assign imem_req        = (r_state == FETCH) && !RST;
   assign imem_addr       = r_pc;
   assign dmem_req        = r_dmemReq;
   assign dmem_we         = r_dmemWe;
   assign dmem_addr       = r_dmemAddr;
   assign dmem_wdata      = r_dmemWdata;
   assign debug_reg_state = r_regs;
   assign halted          = r_halted;

   always_comb begin
      w_aluOut = '0;
      case (w_op)
         OP_ADD:  w_aluOut = r_rsVal + r_rtVal;
         OP_SUB:  w_aluOut = r_rsVal - r_rtVal;
         OP_AND:  w_aluOut = r_rsVal & r_rtVal;
         OP_OR:   w_aluOut = r_rsVal | r_rtVal;
         OP_XOR:  w_aluOut = r_rsVal ^ r_rtVal;
         OP_SLT:  w_aluOut = REG_WIDTH'($signed(r_rsVal) < $signed(r_rtVal));
         default: w_aluOut = r_rsVal + w_imm;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= FETCH;
         r_pc        <= '0;
         r_instr     <= '0;
         r_rsVal     <= '0;
         r_rtVal     <= '0;
         r_result    <= '0;
         r_regs      <= '0;
         r_halted    <= 1'b0;
         r_dmemReq   <= 1'b0;
         r_dmemWe    <= 1'b0;
         r_dmemAddr  <= '0;
         r_dmemWdata <= '0;
      end else begin
         case (r_state)
            FETCH: begin
               if (imem_ready) begin
                  r_instr <= imem_rdata;
                  r_state <= DECODE;
               end
            end
            DECODE: begin
               r_rsVal <= r_regs[w_rs];
               r_rtVal <= r_regs[w_rt];
               r_state <= EXECUTE;
            end
            EXECUTE: begin
               r_result <= w_aluOut;
               case (w_op)
                  OP_HALT: begin
                     r_halted <= 1'b1;
                     r_state  <= HALT;
                  end
                  OP_LW, OP_SW: begin
                     r_dmemReq   <= 1'b1;
                     r_dmemWe    <= (w_op == OP_SW);
                     r_dmemAddr  <= ADDR_WIDTH'(w_aluOut);
                     r_dmemWdata <= r_rtVal;
                     r_state     <= MEM;
                  end
                  OP_BEQ: begin
                     r_pc    <= (r_rsVal == r_rtVal) ? (w_pcInc + w_immPc) : w_pcInc;
                     r_state <= FETCH;
                  end
                  OP_JMP: begin
                     r_pc    <= ADDR_WIDTH'(r_rsVal);
                     r_state <= FETCH;
                  end
                  OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT, OP_ADDI: begin
                     r_state <= WRITEBACK;
                  end
                  default: begin
                     r_pc    <= w_pcInc;
                     r_state <= FETCH;
                  end
               endcase
            end
            MEM: begin
               if (dmem_ready) begin
                  r_dmemReq <= 1'b0;
                  r_dmemWe  <= 1'b0;
                  if (r_dmemWe) begin
                     r_pc    <= w_pcInc;
                     r_state <= FETCH;
                  end else begin
                     r_result <= dmem_rdata;
                     r_state  <= WRITEBACK;
                  end
               end
            end
            WRITEBACK: begin
               // r0 is hardwired to zero, so its write is simply dropped.
               if (w_dest != '0) begin
                  r_regs[w_dest] <= r_result;
               end
               r_pc    <= w_pcInc;
               r_state <= FETCH;
            end
            HALT: begin
               r_state <= HALT;
            end
            default: begin
               r_state <= FETCH;
            end
         endcase
      end
   end
endmodule

// File: doc/cpu_multicycle.md
Name: cpu_multicycle

Overview:
Parametrised multi-cycle successor to the single-cycle core. Fetches instructions from, and loads/stores data to, external memories over req/ready handshakes, so the core tolerates wait states. Internal register file, ALU, branch/jump and halt logic are sequenced by a state machine. Sits at the top of the little-computer datapath in place of the single-cycle core.

Parameters:
REG_WIDTH, 16, datapath and register width
NUM_REGS, 8, register count (power of 2, >=2); RW = clog2(NUM_REGS)
INSTR_WIDTH, 16, instruction width; must be >= 4+3*RW
ADDR_WIDTH, 16, pc and memory address width

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous active-high reset
imem_req  out  1  instruction fetch request
imem_addr  out  ADDR_WIDTH  fetch address (= pc)
imem_ready  in  1  fetch complete; imem_rdata valid this cycle
imem_rdata  in  INSTR_WIDTH  fetched instruction
dmem_req  out  1  data access request
dmem_we  out  1  1=store, 0=load
dmem_addr  out  ADDR_WIDTH  data address
dmem_wdata  out  REG_WIDTH  store data
dmem_ready  in  1  access complete; dmem_rdata valid for loads
dmem_rdata  in  REG_WIDTH  load data
debug_reg_state  out  NUM_REGS x REG_WIDTH  live register file contents
halted  out  1  core stopped on HALT

Behaviour:
- Single clock CLK; reset is synchronous, active-high on RST; it overrides everything incl. mid-transaction: next edge pc=0, all regs=0, state=FETCH, halted=0, imem_req=dmem_req=dmem_we=0; any pending memory transaction is abandoned.
- Instruction fields: op=[IW-1:IW-4], rs=next RW bits, rt=next RW bits, rd=next RW bits below rt; imm = all bits below rt, sign-extended to REG_WIDTH.
- Opcodes: 0 HALT; 1 ADD, 2 SUB, 3 AND, 4 OR, 5 XOR, 6 SLT (signed, result 1/0) — all rd = rs op rt; 7 ADDI rt=rs+imm; 8 LW rt=mem[rs+imm]; 9 SW mem[rs+imm]=rt; 10 BEQ if rs==rt pc=pc+1+imm; 11 JMP pc=rs[ADDR_WIDTH-1:0]; 12-15 NOP (pc+1).
- r0 reads 0; writes to r0 discarded. Arithmetic wraps mod 2^REG_WIDTH; pc arithmetic wraps mod 2^ADDR_WIDTH; addresses take low ADDR_WIDTH bits.
- States: FETCH, DECODE, EXECUTE, MEM, WRITEBACK, HALT.
- FETCH: imem_req=1, imem_addr=pc held stable; on edge with imem_ready=1 latch instr -> DECODE; else stay.
- DECODE: latch rs/rt values -> EXECUTE.
- EXECUTE: latch ALU result/address. HALT -> HALT state (pc unchanged). LW/SW -> MEM. BEQ/JMP/NOP: update pc -> FETCH. ALU/ADDI -> WRITEBACK.
- MEM: dmem_req=1, dmem_we, dmem_addr, dmem_wdata stable until dmem_ready=1 sampled; then SW: pc+1 -> FETCH; LW: latch dmem_rdata -> WRITEBACK.
- WRITEBACK: write destination reg, pc+1 -> FETCH.
- Requests deasserted in all other states; ready ignored when no request outstanding. Ready may be high in the same cycle req rises (zero wait).
- Cycles per instr with zero-wait memory: ALU/ADDI 4, LW 5, SW 4, BEQ/JMP/NOP 3; each ready-low cycle adds 1.
- HALT: halted=1 (registered, asserts the cycle after EXECUTE), no requests, no register/pc change, until RST.
- debug_reg_state reflects writes the cycle after WRITEBACK edge.

Test Plan:
- Reset then program ADDI r1,r0,5; ADDI r2,r0,-3; ADD r3,r1,r2; HALT, zero-wait -> r1=5, r2=0xFFFD, r3=2, halted=1 after 4+4+4+3 cycles, pc=3.
- Same program with imem_ready low 2 cycles per fetch -> identical results, imem_addr/imem_req stable through waits, each instr +2 cycles.
- SW r1,[r0+4] with r1=0x1234 then LW r4,[r0+4] against model memory, dmem_ready delayed 3 cycles -> store seen addr 4 data 0x1234 we=1; r4=0x1234.
- BEQ r1,r1,+2 at pc=5 -> next fetch 8; BEQ r1,r2 unequal -> 6; JMP r5 with r5=0x20 -> fetch 0x20; ADDI r0,r0,7 -> r0 stays 0.
- Assert RST during MEM with dmem_req high -> next cycle dmem_req=0, pc=0, regs 0, fetch restarts at 0.
- ADD 0x7FFF+0x0001 -> 0x8000; SLT 0xFFFF,0x0001 -> 1; pc wrap at ADDR_WIDTH=4 from 15 -> 0.
